// File: rtl/anti_difference_rounding_mc_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel anti-difference/rounding stage.
// Constant functions only; nothing here infers logic.
package adr_pkg;

    localparam int     WIDTH_DEF      = 24;
    localparam int     GUARD_DEF      = 8;
    localparam int     ACC_WIDTH      = WIDTH_DEF + GUARD_DEF;
    localparam int     FRAC_DEF       = 16;
    localparam int     RECIP_FRAC_DEF = 24;
    localparam longint TWO_LAMBDA_DEF = 98304;
    localparam longint INV_TL_DEF     = 11184811;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Channel tag width; a single-channel build still carries a 1-bit tag.
    function automatic int chan_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic longint round_const(input int shift);
        return longint'(1) << (shift - 1);
    endfunction

    function automatic longint inv_two_lambda(input longint two_lambda, input int frac, input int rfrac);
        longint num;
        num = longint'(1) << (frac + rfrac);
        return (num + two_lambda / 2) / two_lambda;
    endfunction

endpackage

// File: rtl/anti_difference_rounding_mc_if.sv
// Sample bus into and out of the anti-difference/rounding stage; no backpressure,
// the producer side drives valid/tag/data and the stage returns rounded samples.
interface anti_difference_rounding_mc_if #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 4
);
    localparam int CW = adr_pkg::chan_w(CHANNELS);

    logic                    valid_in;
    logic [CW-1:0]           chan_in;
    logic signed [WIDTH-1:0] residual_diff_in;
    logic                    valid_out;
    logic [CW-1:0]           chan_out;
    logic signed [WIDTH-1:0] residual_out;
    logic                    ovf_out;
    logic                    ovf_sticky;

    modport master (
        output valid_in, chan_in, residual_diff_in,
        input  valid_out, chan_out, residual_out, ovf_out, ovf_sticky
    );

    modport slave (
        input  valid_in, chan_in, residual_diff_in,
        output valid_out, chan_out, residual_out, ovf_out, ovf_sticky
    );

endinterface

// File: rtl/anti_difference_rounding_mc_round.sv
// Rounds an accumulator to the nearest multiple of 2*lambda via reciprocal multiply, then saturates.
// Latency 2 enabled cycles; no backpressure, en=0 freezes every register.
module adr_round_2lambda
    import adr_pkg::*;
#(
    parameter int     WIDTH          = 24,
    parameter int     ACC_W          = 32,
    parameter int     CW             = 2,
    parameter int     FRAC           = 16,
    parameter int     RECIP_FRAC     = 24,
    parameter longint TWO_LAMBDA     = 98304,
    parameter longint INV_TWO_LAMBDA = 11184811
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    vld_i,
    input  logic [CW-1:0]           chan_i,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    ovf_i,
    output logic                    vld_o,
    output logic [CW-1:0]           chan_o,
    output logic signed [WIDTH-1:0] res_o,
    output logic                    ovf_o
);
    localparam int PW = ACC_W + RECIP_FRAC + 2;
    localparam int SH = FRAC + RECIP_FRAC;

    localparam logic signed [PW-1:0] INV_C = PW'(INV_TWO_LAMBDA);
    localparam logic signed [PW-1:0] RND_C = PW'(round_const(SH));
    localparam logic signed [PW-1:0] TL_C  = PW'(TWO_LAMBDA);
    localparam logic signed [PW-1:0] MAX_C = PW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_C = ~MAX_C;

    logic signed [PW-1:0]    acc_x, p_d, p_q;
    logic signed [PW-1:0]    rsum_d, q_d, y_d;
    logic signed [WIDTH-1:0] res_d, res_q;
    logic                    sat_d;
    logic                    vld1_q, ovf1_q, vld_q, ovf_q;
    logic [CW-1:0]           chan1_q, chan_q;

    always_comb begin
        acc_x  = PW'(acc_i);
        p_d    = acc_x * INV_C;
        rsum_d = p_q + RND_C;
        q_d    = rsum_d >>> SH;
        y_d    = q_d * TL_C;
        sat_d  = 1'b0;
        res_d  = y_d[WIDTH-1:0];
        if (y_d > MAX_C) begin
            res_d = MAX_C[WIDTH-1:0];
            sat_d = 1'b1;
        end else if (y_d < MIN_C) begin
            res_d = MIN_C[WIDTH-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            vld1_q  <= 1'b0;
            chan1_q <= '0;
            ovf1_q  <= 1'b0;
            vld_q   <= 1'b0;
            chan_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (en_i) begin
            p_q     <= p_d;
            vld1_q  <= vld_i;
            chan1_q <= chan_i;
            ovf1_q  <= ovf_i;
            vld_q   <= vld1_q;
            // Data/tag/flag hold their last sample between valid pulses.
            if (vld1_q) begin
                chan_q <= chan1_q;
                res_q  <= res_d;
                ovf_q  <= ovf1_q | sat_d;
            end
        end
    end

    assign vld_o  = vld_q;
    assign chan_o = chan_q;
    assign res_o  = res_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/anti_difference_rounding_mc.sv
// Per-channel ORDER-deep integrator cascade feeding the 2*lambda rounder; 3 enabled cycles in to out.
// No backpressure: one sample per cycle, clk_en=0 freezes all state, clear drops the same-cycle sample.
module anti_difference_rounding_mc
    import adr_pkg::*;
#(
    parameter int     WIDTH          = WIDTH_DEF,
    parameter int     FRAC           = FRAC_DEF,
    parameter int     ORDER          = 2,
    parameter int     CHANNELS       = 4,
    parameter int     GUARD          = GUARD_DEF,
    parameter longint TWO_LAMBDA     = TWO_LAMBDA_DEF,
    parameter int     RECIP_FRAC     = RECIP_FRAC_DEF,
    parameter longint INV_TWO_LAMBDA = INV_TL_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk_en,
    input  logic                          clear,
    anti_difference_rounding_mc_if.slave  bus
);
    localparam int ACC_W = WIDTH + GUARD;
    localparam int CW    = chan_w(CHANNELS);

    if (ORDER < 1 || ORDER > 4) begin : g_bad_order
        $error("ORDER must be 1..4");
    end
    if (INV_TWO_LAMBDA != inv_two_lambda(TWO_LAMBDA, FRAC, RECIP_FRAC)) begin : g_bad_recip
        $error("INV_TWO_LAMBDA does not match TWO_LAMBDA/FRAC/RECIP_FRAC");
    end

    logic signed [ACC_W-1:0] s_q   [CHANNELS][ORDER];
    logic signed [ACC_W-1:0] chain [ORDER+1];
    logic signed [ACC_W:0]   sum;
    logic                    accept, wrap_d;
    logic [CW-1:0]           cidx;

    logic                    vld0_q, wrap0_q, sticky_q;
    logic [CW-1:0]           chan0_q;
    logic signed [ACC_W-1:0] acc0_q;

    logic                    vld_w, ovf_w;
    logic [CW-1:0]           chan_w_o;
    logic signed [WIDTH-1:0] res_w;

    // The whole cascade for one channel resolves in one cycle, so same-channel samples never stall.
    always_comb begin
        accept   = bus.valid_in && !clear && (32'(bus.chan_in) < CHANNELS);
        cidx     = accept ? bus.chan_in : '0;
        wrap_d   = 1'b0;
        sum      = '0;
        chain[0] = ACC_W'(bus.residual_diff_in);
        for (int k = 0; k < ORDER; k++) begin
            sum        = {s_q[cidx][k][ACC_W-1], s_q[cidx][k]} + {chain[k][ACC_W-1], chain[k]};
            chain[k+1] = sum[ACC_W-1:0];
            wrap_d     = wrap_d | (sum[ACC_W] ^ sum[ACC_W-1]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < ORDER; k++)
                    s_q[c][k] <= '0;
            vld0_q   <= 1'b0;
            chan0_q  <= '0;
            acc0_q   <= '0;
            wrap0_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else if (clk_en) begin
            vld0_q <= accept;
            if (accept) begin
                chan0_q <= bus.chan_in;
                acc0_q  <= chain[ORDER];
                wrap0_q <= wrap_d;
            end
            if (clear) begin
                for (int c = 0; c < CHANNELS; c++)
                    for (int k = 0; k < ORDER; k++)
                        s_q[c][k] <= '0;
                sticky_q <= 1'b0;
            end else begin
                if (accept)
                    for (int k = 0; k < ORDER; k++)
                        s_q[cidx][k] <= chain[k+1];
                if (vld_w && ovf_w)
                    sticky_q <= 1'b1;
            end
        end
    end

    adr_round_2lambda #(
        .WIDTH          (WIDTH),
        .ACC_W          (ACC_W),
        .CW             (CW),
        .FRAC           (FRAC),
        .RECIP_FRAC     (RECIP_FRAC),
        .TWO_LAMBDA     (TWO_LAMBDA),
        .INV_TWO_LAMBDA (INV_TWO_LAMBDA)
    ) u_round (
        .clk    (clk),
        .rst_n  (reset_n),
        .en_i   (clk_en),
        .vld_i  (vld0_q),
        .chan_i (chan0_q),
        .acc_i  (acc0_q),
        .ovf_i  (wrap0_q),
        .vld_o  (vld_w),
        .chan_o (chan_w_o),
        .res_o  (res_w),
        .ovf_o  (ovf_w)
    );

    assign bus.valid_out    = vld_w;
    assign bus.chan_out     = chan_w_o;
    assign bus.residual_out = res_w;
    assign bus.ovf_out      = ovf_w;
    assign bus.ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_anti_difference_rounding_mc.sv
// Drives an ORDER=1 and an ORDER=2 instance with identical stimulus and checks both
// against an arithmetic reference model of the integrate-and-round rule.
module tb_anti_difference_rounding_mc;

    localparam int     NCH  = 3;
    localparam longint TL   = 98304;
    localparam longint INV  = 11184811;
    localparam longint MAXV = 8388607;
    localparam longint MINV = -8388608;

    typedef struct {
        logic signed [63:0] y;
        int                 ch;
        logic               ovf;
        int                 due;
    } exp_t;

    logic clk, reset_n, clk_en, clear;
    int   n_assert, n_fail, ecnt;

    exp_t               expq  [2][$];
    logic signed [63:0] obs_y [2][$];
    logic               last_ovf [2];
    longint             st [2][NCH][4];
    bit                 exp_sticky [2];

    anti_difference_rounding_mc_if #(.WIDTH(24), .CHANNELS(NCH)) bus0 ();
    anti_difference_rounding_mc_if #(.WIDTH(24), .CHANNELS(NCH)) bus1 ();

    anti_difference_rounding_mc #(.ORDER(1), .CHANNELS(NCH)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clear(clear), .bus(bus0));
    anti_difference_rounding_mc #(.ORDER(2), .CHANNELS(NCH)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clear(clear), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (reset_n && clk_en) ecnt = ecnt + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: exact sums wrapped to 32 bits, then nearest-multiple-of-2*lambda via the reciprocal rule.
    task automatic model(input int o, input int ord, input int ch, input int x, input bit clr);
        exp_t   e;
        longint v, t, tw;
        bit     w;
        if (clr) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < 4; k++) st[o][c][k] = 0;
            exp_sticky[o] = 0;
            return;
        end
        if (ch >= NCH) return;
        v = x;
        w = 0;
        for (int k = 0; k < ord; k++) begin
            t  = st[o][ch][k] + v;
            tw = longint'(int'(t));
            if (tw != t) w = 1;
            st[o][ch][k] = tw;
            v = tw;
        end
        v = (v * INV + (longint'(1) << 39)) >>> 40;
        v = v * TL;
        if (v > MAXV) begin v = MAXV; w = 1; end
        else if (v < MINV) begin v = MINV; w = 1; end
        e.y = v; e.ch = ch; e.ovf = w; e.due = ecnt + 3;
        expq[o].push_back(e);
    endtask

    task automatic mon(input int o, input logic v, input int ch, input logic signed [63:0] r, input logic ov);
        exp_t e;
        bit   pending;
        if (!clk_en) return;
        pending = (expq[o].size() > 0) && (expq[o][0].due <= ecnt);
        if (v || pending) begin
            chk($sformatf("valid_timing_inst%0d", o), 64'(v), 64'(pending));
            if (pending) begin
                e = expq[o].pop_front();
                if (v) begin
                    chk($sformatf("residual_inst%0d", o), r, e.y);
                    chk($sformatf("chan_inst%0d", o), 64'(ch), 64'(e.ch));
                    chk($sformatf("ovf_inst%0d", o), 64'(ov), 64'(e.ovf));
                    if (e.ovf && !clear) exp_sticky[o] = 1;
                end
            end
            if (v) begin
                obs_y[o].push_back(r);
                last_ovf[o] = ov;
            end
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            mon(0, bus0.valid_out, int'(bus0.chan_out), 64'(bus0.residual_out), bus0.ovf_out);
            mon(1, bus1.valid_out, int'(bus1.chan_out), 64'(bus1.residual_out), bus1.ovf_out);
        end
    end

    task automatic send(input int ch, input int x, input bit clr);
        bus0.valid_in = 1'b1; bus0.chan_in = 2'(ch); bus0.residual_diff_in = 24'(x);
        bus1.valid_in = 1'b1; bus1.chan_in = 2'(ch); bus1.residual_diff_in = 24'(x);
        clear = clr;
        model(0, 1, ch, x, clr);
        model(1, 2, ch, x, clr);
        @(negedge clk);
        bus0.valid_in = 1'b0;
        bus1.valid_in = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model(0, 1, 0, 0, 1);
        model(1, 2, 0, 0, 1);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_obs();
        obs_y[0].delete();
        obs_y[1].delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid0"}, 64'(bus0.valid_out), 0);
        chk({tag, "_chan0"}, 64'(bus0.chan_out), 0);
        chk({tag, "_res0"}, 64'(bus0.residual_out), 0);
        chk({tag, "_ovf0"}, 64'(bus0.ovf_out), 0);
        chk({tag, "_sticky0"}, 64'(bus0.ovf_sticky), 0);
        chk({tag, "_valid1"}, 64'(bus1.valid_out), 0);
        chk({tag, "_res1"}, 64'(bus1.residual_out), 0);
        chk({tag, "_sticky1"}, 64'(bus1.ovf_sticky), 0);
    endtask

    task automatic reset_model();
        for (int o = 0; o < 2; o++) begin
            expq[o].delete();
            exp_sticky[o] = 0;
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < 4; k++) st[o][c][k] = 0;
        end
    endtask

    longint round_in  [4];
    longint round_exp [4];

    initial begin
        n_assert = 0; n_fail = 0; ecnt = 0;
        reset_n = 1'b0; clk_en = 1'b1; clear = 1'b0;
        bus0.valid_in = 1'b0; bus0.chan_in = '0; bus0.residual_diff_in = '0;
        bus1.valid_in = 1'b0; bus1.chan_in = '0; bus1.residual_diff_in = '0;
        reset_model();
        idle(2);
        chk_zero("reset");
        reset_n = 1'b1;
        idle(1);

        // Single sample, ORDER=1 channel 0.
        clr_obs();
        send(0, 98304, 0);
        idle(4);
        chk("basic_count", 64'(obs_y[0].size()), 1);
        chk("basic_res", obs_y[0][0], 98304);
        chk("basic_ovf", 64'(last_ovf[0]), 0);

        // Rounding boundaries on a freshly cleared channel.
        round_in  = '{49152, 49151, -49151, -98304};
        round_exp = '{98304, 0, 0, -98304};
        for (int i = 0; i < 4; i++) begin
            do_clear();
            clr_obs();
            send(1, int'(round_in[i]), 0);
            idle(4);
            chk($sformatf("round_count_%0d", i), 64'(obs_y[0].size()), 1);
            chk($sformatf("round_res_%0d", i), obs_y[0][0], round_exp[i]);
        end

        // ORDER=2 step response on channel 1.
        do_clear();
        clr_obs();
        send(1, 98304, 0); send(1, 0, 0); send(1, 0, 0);
        idle(4);
        chk("o2_count", 64'(obs_y[1].size()), 3);
        chk("o2_res0", obs_y[1][0], 98304);
        chk("o2_res1", obs_y[1][1], 196608);
        chk("o2_res2", obs_y[1][2], 294912);

        // Interleaved channels stay independent.
        do_clear();
        clr_obs();
        send(0, 98304, 0); send(2, 98304, 0); send(0, 98304, 0); send(2, 98304, 0);
        idle(4);
        chk("ilv_res0", obs_y[0][0], 98304);
        chk("ilv_res1", obs_y[0][1], 98304);
        chk("ilv_res2", obs_y[0][2], 196608);
        chk("ilv_res3", obs_y[0][3], 196608);

        // Five-cycle freeze mid-stream.
        do_clear();
        clr_obs();
        send(0, 98304, 0); send(0, 98304, 0);
        clk_en = 1'b0;
        idle(5);
        clk_en = 1'b1;
        send(0, 98304, 0);
        idle(5);
        chk("freeze_count", 64'(obs_y[0].size()), 3);
        chk("freeze_res2", obs_y[0][2], 294912);

        // Clear coinciding with a valid sample discards it.
        do_clear();
        clr_obs();
        send(2, 98304, 0); send(2, 98304, 1); send(2, 98304, 0);
        idle(5);
        chk("clrv_count", 64'(obs_y[0].size()), 2);
        chk("clrv_res1", obs_y[0][1], 98304);

        // Hammer +max until the ORDER=1 accumulator wraps.
        do_clear();
        clr_obs();
        repeat (300) send(0, 8388607, 0);
        idle(5);
        chk("wrap_res", obs_y[0][obs_y[0].size()-1], MINV);
        chk("wrap_ovf", 64'(last_ovf[0]), 1);
        chk("wrap_sticky0", 64'(bus0.ovf_sticky), 1);
        chk("wrap_sticky1", 64'(bus1.ovf_sticky), 64'(exp_sticky[1]));
        send(1, 0, 0);
        idle(5);
        chk("sticky_hold", 64'(bus0.ovf_sticky), 1);
        do_clear();
        idle(2);
        chk("sticky_clr0", 64'(bus0.ovf_sticky), 0);
        chk("sticky_clr1", 64'(bus1.ovf_sticky), 0);

        // Randomized traffic with clears, stalls and out-of-range tags.
        for (int i = 0; i < 400; i++) begin
            int r, x;
            r = int'($urandom_range(0, 19));
            if (r == 19) x = int'($urandom_range(0, 16777215)) - 8388608;
            else         x = int'($urandom_range(0, 2097152)) - 1048576;
            if (r == 0) do_clear();
            else if (r < 3) begin
                clk_en = 1'b0;
                @(negedge clk);
                clk_en = 1'b1;
            end else send(int'($urandom_range(0, 3)), x, ($urandom_range(0, 29) == 0));
        end
        idle(6);
        chk("rand_sticky0", 64'(bus0.ovf_sticky), 64'(exp_sticky[0]));
        chk("rand_sticky1", 64'(bus1.ovf_sticky), 64'(exp_sticky[1]));

        // Asynchronous reset in the middle of traffic.
        send(0, 1000, 0); send(1, 2000, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        reset_model();
        idle(2);
        reset_n = 1'b1;
        clr_obs();
        send(0, 98304, 0);
        idle(4);
        chk("post_rst_res", obs_y[0][0], 98304);

        idle(4);
        chk("drain0", 64'(expq[0].size()), 0);
        chk("drain1", 64'(expq[1].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
